button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Sits between the raw push-button pins and the game controller's hit checker.
- Each input is synchronised, debounced and polarity-normalised.
- Produces clean held levels, single-cycle press/release pulses, an encoded "which button was pressed" event, and an any-button-held flag.
- The controller's hit/miss logic compares press_idx against its 2-bit random target, and uses any_down to wait for release before re-arming.

Parameters:
- N_BTN, 4, number of buttons conditioned.
- IDX_W, 2, width of press_idx; 2**IDX_W >= N_BTN is required.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a change (5 ms at 50 MHz); legal range 1 to 2**CNT_W-1.
- CNT_W, 18, debounce counter width.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_raw  in  N_BTN  unsynchronised button pins.
- en  in  1  event enable; gates pulses only.
- btn_level  out  N_BTN  debounced state, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse per button on accepted press.
- btn_release  out  N_BTN  one-cycle pulse per button on accepted release.
- any_down  out  1  OR of btn_level.
- press_valid  out  1  one-cycle pulse: at least one press accepted this cycle.
- press_idx  out  IDX_W  lowest index set in btn_press; valid with press_valid.
- press_multi  out  1  press was ambiguous; valid with press_valid.

Behaviour:
- Reset (asynchronous, active-high) clears all of the following to released/0:
  - sync flops (post-polarity value 0), stable state and counters;
  - all outputs.
- A button physically held through reset is reported as a fresh press once debounced after reset deassertion. This is intentional.
- Polarity: ACTIVE_LOW inverts btn_raw ahead of the first sync flop. All internal logic is active-high.
- Synchroniser: 2 flops per bit. sync = second flop.
- Debounce, per button, independently:
  - sync == stable: counter cleared to 0.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable toggles and counter clears.
  - otherwise: counter increments.
  - Any bounce (sync returns to stable) restarts the count.
  - Counter never wraps. It saturates implicitly because the toggle clears it.
- Latency: count edge 1 as the first rising edge that samples a new, constant raw value. btn_level changes at rising edge DEBOUNCE_CYCLES+2.
- Pulses, all registered and updating on the same edge that toggles stable:
  - btn_press[i] = 1 for exactly one cycle when stable[i] goes 0->1 and en = 1.
  - btn_release[i] = 1 for exactly one cycle when stable[i] goes 1->0 and en = 1.
- en = 0: pulses and press_valid are forced 0. btn_level and any_down keep tracking. Toggles that occur while en = 0 are lost, not deferred.
- Encoded event, registered on the same edge as btn_press:
  - press_valid = |btn_press.
  - press_idx = lowest set index, 0 when press_valid = 0.
  - press_multi = 1 if more than one button presses in the same cycle, or if any other button's btn_level was already 1 in the cycle before the press.
- Simultaneous press on one button and release on another in the same cycle: both pulses are issued. press_multi considers only the pre-edge levels of other buttons.
- any_down: registered OR of the updated btn_level, so it rises in the same cycle as the first btn_press.
- Reset mid-count: the count is discarded. No pulse is emitted on reset entry or exit.

Test Plan:
1. DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, en=1; btn_raw[2] driven 1->0 and held -> btn_level[2] and btn_press[2] rise at edge 6; btn_press width 1 cycle; press_valid=1, press_idx=2, press_multi=0, any_down=1.
2. Same config; btn_raw[1] pressed, then toggled released/pressed every 2 cycles for 20 cycles, then held -> no pulse during the bounce; exactly one btn_press[1] 6 edges after the final stable edge.
3. btn_raw[0] and btn_raw[3] pressed on the same edge -> btn_press=4'b1001 for one cycle; press_idx=0, press_multi=1.
4. Button 1 held and debounced, then button 2 pressed -> press_idx=2, press_multi=1. Release button 1 -> btn_release[1] one cycle, any_down stays 1.
5. en=0 while button 3 is pressed and debounced -> btn_level[3]=1, no btn_press, press_valid=0. Raise en -> still no pulse. Release with en=1 -> btn_release[3] pulse.
6. Button 0 pressed; rst asserted mid-count (2 cycles into debounce) -> all outputs 0 immediately. Button still held after rst deasserts -> btn_press[0] at edge 6 after deassertion.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and polarity-normalise push buttons, emitting levels, pulses and an encoded press event
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset; clears all state and outputs
//   btn_raw      unsynchronised button pins (polarity set by ACTIVE_LOW)
//   en           event enable; gates press/release pulses and the encoded event only
//   btn_level    debounced state per button, 1 = pressed
//   btn_press    one-cycle pulse per button on an accepted press
//   btn_release  one-cycle pulse per button on an accepted release
//   any_down     OR of the debounced levels, registered alongside them
//   press_valid  one-cycle pulse when at least one press is accepted
//   press_idx    lowest pressing index, 0 when press_valid is 0
//   press_multi  press was ambiguous (several presses, or another button already held)
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int IDX_W           = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter bit ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             any_down,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx,
    output logic             press_multi
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] pol;
    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] press_q, press_d, release_q, release_d;
    logic             any_q, valid_q, valid_d, multi_q, multi_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Inverting before the first flop lets reset's all-zero state mean "released".
    assign pol = ACTIVE_LOW ? ~btn_raw : btn_raw;

    always_comb begin
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i]  = ~stable_q[i];
                    press_d[i]   = en & ~stable_q[i];
                    release_d[i] = en & stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        valid_d = |press_d;
        idx_d   = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_d[i]) idx_d = IDX_W'(i);
        end
        // A pressing button's own pre-edge level is 0, so any set bit in
        // stable_q belongs to another button that was already held.
        multi_d = valid_d && (($countones(press_d) > 1) || (|stable_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            multi_q   <= 1'b0;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= pol;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            any_q     <= |stable_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            multi_q   <= multi_d;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign any_down    = any_q;
    assign press_valid = valid_q;
    assign press_idx   = idx_q;
    assign press_multi = multi_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed self-checking bench for button_conditioner
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       en;
    logic [3:0] btn_level, btn_press, btn_release;
    logic       any_down, press_valid, press_multi;
    logic [1:0] press_idx;
    int         n_chk = 0;
    int         n_fail = 0;

    button_conditioner #(
        .N_BTN(4), .IDX_W(2), .DEBOUNCE_CYCLES(4), .CNT_W(18), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .en(en),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .any_down(any_down), .press_valid(press_valid), .press_idx(press_idx),
        .press_multi(press_multi)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on negedges; each step crosses one rising edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; btn_raw = 4'hF;
        step(2);
        n_chk++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL reset_level got %b exp 0000", btn_level); end
        n_chk++; if (any_down !== 1'b0) begin n_fail++; $display("FAIL reset_any got %b exp 0", any_down); end
        n_chk++; if (press_valid !== 1'b0 || btn_press !== 4'b0000) begin n_fail++; $display("FAIL reset_press got %b/%b exp 0/0000", press_valid, btn_press); end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_single_press;
        btn_raw = 4'b1011;
        step(5);
        n_chk++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL t1_early_level got %b exp 0000", btn_level); end
        step(1);
        n_chk++; if (btn_level !== 4'b0100) begin n_fail++; $display("FAIL t1_level got %b exp 0100", btn_level); end
        n_chk++; if (btn_press !== 4'b0100) begin n_fail++; $display("FAIL t1_press got %b exp 0100", btn_press); end
        n_chk++; if (press_valid !== 1'b1) begin n_fail++; $display("FAIL t1_valid got %b exp 1", press_valid); end
        n_chk++; if (press_idx !== 2'd2) begin n_fail++; $display("FAIL t1_idx got %0d exp 2", press_idx); end
        n_chk++; if (press_multi !== 1'b0) begin n_fail++; $display("FAIL t1_multi got %b exp 0", press_multi); end
        n_chk++; if (any_down !== 1'b1) begin n_fail++; $display("FAIL t1_any got %b exp 1", any_down); end
        step(1);
        n_chk++; if (btn_press !== 4'b0000 || press_valid !== 1'b0) begin n_fail++; $display("FAIL t1_width got %b/%b exp 0000/0", btn_press, press_valid); end
        n_chk++; if (press_idx !== 2'd0) begin n_fail++; $display("FAIL t1_idx_idle got %0d exp 0", press_idx); end
        btn_raw = 4'hF;
        step(6);
        n_chk++; if (btn_release !== 4'b0100) begin n_fail++; $display("FAIL t1_release got %b exp 0100", btn_release); end
        n_chk++; if (any_down !== 1'b0) begin n_fail++; $display("FAIL t1_any_off got %b exp 0", any_down); end
        step(1);
        n_chk++; if (btn_release !== 4'b0000) begin n_fail++; $display("FAIL t1_rel_width got %b exp 0000", btn_release); end
    endtask

    task automatic test_bounce;
        logic [3:0] seen;
        seen = 4'b0000;
        btn_raw = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 2; j++) begin
                step(1);
                seen = seen | btn_press | btn_release;
            end
            btn_raw[1] = ~btn_raw[1];
        end
        n_chk++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL t2_bounce_pulse got %b exp 0000", seen); end
        for (int j = 0; j < 5; j++) begin
            step(1);
            seen = seen | btn_press;
        end
        n_chk++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL t2_early_press got %b exp 0000", seen); end
        step(1);
        n_chk++; if (btn_press !== 4'b0010) begin n_fail++; $display("FAIL t2_press got %b exp 0010", btn_press); end
        step(1);
        n_chk++; if (btn_press !== 4'b0000) begin n_fail++; $display("FAIL t2_width got %b exp 0000", btn_press); end
        btn_raw = 4'hF;
        step(7);
        n_chk++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL t2_released got %b exp 0000", btn_level); end
    endtask

    task automatic test_simultaneous;
        btn_raw = 4'b0110;
        step(6);
        n_chk++; if (btn_press !== 4'b1001) begin n_fail++; $display("FAIL t3_press got %b exp 1001", btn_press); end
        n_chk++; if (press_idx !== 2'd0) begin n_fail++; $display("FAIL t3_idx got %0d exp 0", press_idx); end
        n_chk++; if (press_multi !== 1'b1) begin n_fail++; $display("FAIL t3_multi got %b exp 1", press_multi); end
        step(1);
        n_chk++; if (btn_press !== 4'b0000) begin n_fail++; $display("FAIL t3_width got %b exp 0000", btn_press); end
        btn_raw = 4'hF;
        step(6);
        n_chk++; if (btn_release !== 4'b1001) begin n_fail++; $display("FAIL t3_release got %b exp 1001", btn_release); end
        step(1);
    endtask

    task automatic test_held_other;
        btn_raw = 4'b1101;
        step(7);
        btn_raw = 4'b1001;
        step(6);
        n_chk++; if (btn_press !== 4'b0100) begin n_fail++; $display("FAIL t4_press got %b exp 0100", btn_press); end
        n_chk++; if (press_idx !== 2'd2) begin n_fail++; $display("FAIL t4_idx got %0d exp 2", press_idx); end
        n_chk++; if (press_multi !== 1'b1) begin n_fail++; $display("FAIL t4_multi got %b exp 1", press_multi); end
        step(1);
        btn_raw = 4'b1011;
        step(6);
        n_chk++; if (btn_release !== 4'b0010) begin n_fail++; $display("FAIL t4_release got %b exp 0010", btn_release); end
        n_chk++; if (any_down !== 1'b1) begin n_fail++; $display("FAIL t4_any got %b exp 1", any_down); end
        n_chk++; if (btn_level !== 4'b0100) begin n_fail++; $display("FAIL t4_level got %b exp 0100", btn_level); end
        step(1);
        n_chk++; if (btn_release !== 4'b0000) begin n_fail++; $display("FAIL t4_rel_width got %b exp 0000", btn_release); end
        btn_raw = 4'hF;
        step(7);
    endtask

    task automatic test_enable;
        logic [3:0] seen;
        seen = 4'b0000;
        en = 1'b0;
        btn_raw = 4'b0111;
        for (int j = 0; j < 6; j++) begin
            step(1);
            seen = seen | btn_press | {3'b000, press_valid};
        end
        n_chk++; if (btn_level !== 4'b1000) begin n_fail++; $display("FAIL t5_level got %b exp 1000", btn_level); end
        n_chk++; if (any_down !== 1'b1) begin n_fail++; $display("FAIL t5_any got %b exp 1", any_down); end
        n_chk++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL t5_gated got %b exp 0000", seen); end
        en = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step(1);
            seen = seen | btn_press | {3'b000, press_valid};
        end
        n_chk++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL t5_deferred got %b exp 0000", seen); end
        btn_raw = 4'hF;
        step(6);
        n_chk++; if (btn_release !== 4'b1000) begin n_fail++; $display("FAIL t5_release got %b exp 1000", btn_release); end
        step(1);
    endtask

    task automatic test_reset_mid;
        btn_raw = 4'b0111;
        step(7);
        btn_raw = 4'b0110;
        step(2);
        rst = 1'b1;
        #1;
        n_chk++; if (btn_level !== 4'b0000 || any_down !== 1'b0) begin n_fail++; $display("FAIL t6_async got %b/%b exp 0000/0", btn_level, any_down); end
        step(2);
        n_chk++; if (btn_press !== 4'b0000 || btn_release !== 4'b0000) begin n_fail++; $display("FAIL t6_in_reset got %b/%b exp 0000/0000", btn_press, btn_release); end
        rst = 1'b0;
        step(5);
        n_chk++; if (btn_press !== 4'b0000 || btn_level !== 4'b0000) begin n_fail++; $display("FAIL t6_early got %b/%b exp 0000/0000", btn_press, btn_level); end
        step(1);
        n_chk++; if (btn_press !== 4'b1001) begin n_fail++; $display("FAIL t6_press got %b exp 1001", btn_press); end
        n_chk++; if (press_idx !== 2'd0 || press_multi !== 1'b1) begin n_fail++; $display("FAIL t6_event got idx %0d multi %b exp 0/1", press_idx, press_multi); end
        step(1);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_held_other();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
